rr_sched_kernel: RTL and testbench
==================================

// Module: rr_sched_kernel
// PURPOSE
//  Time-multiplexed round-robin crossbar between NCONSUMERS requesters and NBANKS x NPORTS PLM
//  memory ports. Each cycle every (bank,port) kernel looks at exactly one consumer, chosen by a
//  rotating pivot. It forwards that consumer's request to the PLM if it is valid and targets
//  that bank. Sits between the consumer request bus and the banked PLM array.
// PARAMETERS
//  NCONSUMERS   8   number of requesters; must be a multiple of NPORTS
//  NBANKS       4   number of PLM banks; power of two
//  NPORTS       2   ports per bank
//  ADDR_WIDTH   10  global request address width
//  VALUE_WIDTH  8   data width
//  Derived: REQ_WIDTH=ADDR_WIDTH+VALUE_WIDTH+2; BANK_BITS=$clog2(NBANKS);
//   PLM_ADDR_WIDTH=ADDR_WIDTH-BANK_BITS; PLM_INPUT_WIDTH=PLM_ADDR_WIDTH+VALUE_WIDTH+1;
//   NKERNELS=NBANKS*NPORTS; STRIDE=NCONSUMERS/NPORTS
// PORTS
//  clk         in   1                          single clock, rising edge
//  reset       in   1                          asynchronous, active-low reset
//  requests    in   [REQ_WIDTH-1:0] x NCONSUMERS       {addr, value, wr, valid}; valid = bit 0
//  plm_inputs  out  [PLM_INPUT_WIDTH-1:0] x NKERNELS   {plm_addr, value, wr}; index = bank*NPORTS+port
// BEHAVIOUR
//  - Request fields: addr=[REQ_WIDTH-1 -: ADDR_WIDTH], value=next VALUE_WIDTH bits, wr=[1], valid=[0].
//  - Bank = addr[ADDR_WIDTH-1 -: BANK_BITS] (top bits); plm_addr = addr[PLM_ADDR_WIDTH-1:0].
//  - Pivot counter p, width $clog2(NCONSUMERS), wraps modulo NCONSUMERS.
//  - Reset asserted: p=0 and every plm_inputs entry = 0, asynchronously.
//  - Each rising edge while out of reset:
//    - p <= p+1 (mod NCONSUMERS).
//    - Every output register loads a selection computed with the NEW pivot value q=p+1.
//    - So after the n-th edge following reset release, the outputs reflect pivot n mod NCONSUMERS.
//  - Kernel (bank b, port k) examines only consumer c=(q + b + k*STRIDE) mod NCONSUMERS.
//    - If requests[c].valid=1 and bank(requests[c].addr)==b: output {plm_addr, value, wr}.
//    - Otherwise the output is all zeros.
//  - No search beyond the single pivot consumer per kernel. No handshake or back-pressure.
//    - A consumer holds its request until it is served. Service happens once per NCONSUMERS
//      cycles per port.
//  - Read requests (wr=0, valid=1) are forwarded with wr=0. The value field is passed through
//    unchanged.
//  - Latency: one registered stage. Requests are sampled at the edge that selects them.
//  - Reset mid-operation restarts the rotation: the first edge after release gives pivot 1.
//  - Requests changing every cycle are legal; only the value present at the sampling edge matters.
// TESTING
//  - Values below use default parameters. Edge n means the n-th edge after reset release.
//  - Single request: req[0]={addr 2,val 25,wr1,v1}.
//    - Edge 4: plm[1]={2,25,1}.
//    - Edge 8: plm[0]={2,25,1}.
//    - plm[0] and plm[1] are zero at edges 1-3 and 5-7.
//  - Two requests on bank 0: req[0]={3,25,1,1}, req[4]={5,50,1,1}.
//    - Edge 4: plm[0]={5,50,1}, plm[1]={3,25,1}.
//    - Edge 8: plm[0]={3,25,1}, plm[1]={5,50,1}.
//    - All other edges: zero.
//  - Bank decode: req[0..3] addr 255/510/765/1020, val 0..3, wr1 v1; req[4] invalid.
//    - Edge 8: plm[0]={255,0,1}, plm[2]={254,1,1}, plm[4]={253,2,1}, plm[6]={252,3,1}.
//    - Edge 8: plm[1], plm[3], plm[5], plm[7] are zero.
//  - Invalid/misrouted: req[0]={addr 300,v0} -> all outputs stay 0.
//    - Set valid=1 -> only bank1 ports fire (plm[2] or plm[3]).
//  - Reset: assert reset asynchronously mid-rotation.
//    - All outputs 0 immediately, without waiting for a clock edge.
//    - After release the schedule restarts exactly as in the single-request case.
//  - Read forward: req[0]={2,7,wr0,v1} -> edge 8: plm[0]={2,7,0}.

Source files
------------

// File: rtl/rr_sched_kernel.sv
// rtl/rr_sched_kernel.sv - rotating-pivot round-robin crossbar from consumer requests to banked PLM ports
module rr_sched_kernel #(
    parameter int NCONSUMERS  = 8,
    parameter int NBANKS      = 4,
    parameter int NPORTS      = 2,
    parameter int ADDR_WIDTH  = 10,
    parameter int VALUE_WIDTH = 8,
    localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2,
    localparam int BANK_BITS       = $clog2(NBANKS),
    localparam int PLM_ADDR_WIDTH  = ADDR_WIDTH - BANK_BITS,
    localparam int PLM_INPUT_WIDTH = PLM_ADDR_WIDTH + VALUE_WIDTH + 1,
    localparam int NKERNELS        = NBANKS * NPORTS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NCONSUMERS*REQ_WIDTH-1:0]     requests,
    output logic [NKERNELS*PLM_INPUT_WIDTH-1:0] plm_inputs
);

    localparam int STRIDE  = NCONSUMERS / NPORTS;
    localparam int PIVOT_W = $clog2(NCONSUMERS);

    logic [PIVOT_W-1:0]                  pivot;
    logic [PIVOT_W-1:0]                  pivot_next;
    logic [NKERNELS*PLM_INPUT_WIDTH-1:0] plm_next;

    // Advance the pivot with an explicit wrap so non-power-of-two consumer counts still rotate correctly.
    always_comb begin
        pivot_next = pivot + 1'b1;
        if (pivot == PIVOT_W'(NCONSUMERS - 1)) begin
            pivot_next = '0;
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        for (genvar k = 0; k < NPORTS; k++) begin : g_port
            int                         cons_idx;
            logic [REQ_WIDTH-1:0]       sel_req;
            logic                       hit;
            logic [PLM_INPUT_WIDTH-1:0] sel_out;

            // Each kernel looks only at the consumer its rotation slot points to under the new pivot.
            always_comb begin
                cons_idx = (int'(pivot_next) + b + k * STRIDE) % NCONSUMERS;
                sel_req  = requests[cons_idx*REQ_WIDTH +: REQ_WIDTH];
                hit      = sel_req[0] &&
                           (sel_req[REQ_WIDTH-1 -: BANK_BITS] == BANK_BITS'(b));
                sel_out  = '0;
                if (hit) begin
                    sel_out = {sel_req[REQ_WIDTH-1-BANK_BITS -: PLM_ADDR_WIDTH],
                               sel_req[VALUE_WIDTH+1:1]};
                end
            end

            assign plm_next[(b*NPORTS+k)*PLM_INPUT_WIDTH +: PLM_INPUT_WIDTH] = sel_out;
        end
    end

    // Single registered stage: pivot and all kernel outputs update together, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pivot      <= '0;
            plm_inputs <= '0;
        end else begin
            pivot      <= pivot_next;
            plm_inputs <= plm_next;
        end
    end

endmodule

// File: tb/tb_rr_sched_kernel.sv
// tb/tb_rr_sched_kernel.sv - directed self-checking bench for rr_sched_kernel
module tb_rr_sched_kernel;

    localparam int NC = 8;
    localparam int NK = 8;
    localparam int RW = 20;
    localparam int PW = 17;

    logic           clk = 1'b0;
    logic           reset;
    logic [NC*RW-1:0] requests;
    logic [NK*PW-1:0] plm_inputs;

    int n_cmp = 0;
    int n_bad = 0;

    rr_sched_kernel dut (
        .clk        (clk),
        .reset      (reset),
        .requests   (requests),
        .plm_inputs (plm_inputs)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mk_req(int addr, int val, bit wr, bit v);
        return {10'(addr), 8'(val), wr, v};
    endfunction

    function automatic logic [PW-1:0] mk_plm(int a, int val, bit wr);
        return {8'(a), 8'(val), wr};
    endfunction

    function automatic logic [PW-1:0] plm(int i);
        return plm_inputs[i*PW +: PW];
    endfunction

    task automatic set_req(int i, logic [RW-1:0] r);
        requests[i*RW +: RW] = r;
    endtask

    task automatic restart();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        requests = '0;
        set_req(0, mk_req(2, 25, 1'b1, 1'b1));
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            n_cmp++;
            if (plm(k) !== '0) begin
                n_bad++;
                $display("FAIL reset plm[%0d] got %h want %h", k, plm(k), {PW{1'b0}});
            end
        end
    endtask

    task automatic test_single(string tag);
        logic [PW-1:0] exp;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++) begin
                exp = '0;
                if ((k == 1 && n == 4) || (k == 0 && n == 8)) exp = mk_plm(2, 25, 1'b1);
                n_cmp++;
                if (plm(k) !== exp) begin
                    n_bad++;
                    $display("FAIL %s e%0d plm[%0d] got %h want %h", tag, n, k, plm(k), exp);
                end
            end
        end
    endtask

    task automatic test_two_bank0();
        logic [PW-1:0] exp;
        requests = '0;
        set_req(0, mk_req(3, 25, 1'b1, 1'b1));
        set_req(4, mk_req(5, 50, 1'b1, 1'b1));
        restart();
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++) begin
                exp = '0;
                if (n == 4 && k == 0) exp = mk_plm(5, 50, 1'b1);
                if (n == 4 && k == 1) exp = mk_plm(3, 25, 1'b1);
                if (n == 8 && k == 0) exp = mk_plm(3, 25, 1'b1);
                if (n == 8 && k == 1) exp = mk_plm(5, 50, 1'b1);
                n_cmp++;
                if (plm(k) !== exp) begin
                    n_bad++;
                    $display("FAIL two_bank0 e%0d plm[%0d] got %h want %h", n, k, plm(k), exp);
                end
            end
        end
    endtask

    task automatic test_bank_decode();
        logic [PW-1:0] exp;
        requests = '0;
        set_req(0, mk_req(255,  0, 1'b1, 1'b1));
        set_req(1, mk_req(510,  1, 1'b1, 1'b1));
        set_req(2, mk_req(765,  2, 1'b1, 1'b1));
        set_req(3, mk_req(1020, 3, 1'b1, 1'b1));
        set_req(4, mk_req(7, 9, 1'b1, 1'b0));
        restart();
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            case (k)
                0:       exp = mk_plm(255, 0, 1'b1);
                2:       exp = mk_plm(254, 1, 1'b1);
                4:       exp = mk_plm(253, 2, 1'b1);
                6:       exp = mk_plm(252, 3, 1'b1);
                default: exp = '0;
            endcase
            n_cmp++;
            if (plm(k) !== exp) begin
                n_bad++;
                $display("FAIL bank_decode plm[%0d] got %h want %h", k, plm(k), exp);
            end
        end
    endtask

    task automatic test_invalid();
        logic [PW-1:0] exp;
        requests = '0;
        set_req(0, mk_req(300, 9, 1'b1, 1'b0));
        restart();
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++) begin
                n_cmp++;
                if (plm(k) !== '0) begin
                    n_bad++;
                    $display("FAIL invalid e%0d plm[%0d] got %h want 0", n, k, plm(k));
                end
            end
        end
        set_req(0, mk_req(300, 9, 1'b1, 1'b1));
        restart();
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++) begin
                exp = '0;
                if ((k == 2 && n == 7) || (k == 3 && n == 3)) exp = mk_plm(44, 9, 1'b1);
                n_cmp++;
                if (plm(k) !== exp) begin
                    n_bad++;
                    $display("FAIL misroute e%0d plm[%0d] got %h want %h", n, k, plm(k), exp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        requests = '0;
        set_req(0, mk_req(2, 25, 1'b1, 1'b1));
        restart();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (plm(1) !== mk_plm(2, 25, 1'b1)) begin
            n_bad++;
            $display("FAIL async_pre plm[1] got %h want %h", plm(1), mk_plm(2, 25, 1'b1));
        end
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < NK; k++) begin
            n_cmp++;
            if (plm(k) !== '0) begin
                n_bad++;
                $display("FAIL async_clear plm[%0d] got %h want 0", k, plm(k));
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_single("after_reset");
    endtask

    task automatic test_read_forward();
        requests = '0;
        set_req(0, mk_req(2, 7, 1'b0, 1'b1));
        restart();
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (plm(0) !== mk_plm(2, 7, 1'b0)) begin
            n_bad++;
            $display("FAIL read_fwd plm[0] got %h want %h", plm(0), mk_plm(2, 7, 1'b0));
        end
    endtask

    initial begin
        reset    = 1'b0;
        requests = '0;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_single("single");
        test_two_bank0();
        test_bank_decode();
        test_invalid();
        test_async_reset();
        test_read_forward();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
